// File: rtl/cache_ram_arbiter.sv
// -----------------------------------------------------------------------------
// cache_ram_arbiter
//
// Shares the single cache-to-RAM bridge port between the I-cache (read-only)
// and the D-cache (read/write). One request is serviced at a time by a
// four-state FSM. The FSM strobes valid to the bridge for one cycle, waits for
// the completion pulse, then returns data with a one-cycle ack. Ties are
// resolved round-robin. A watchdog aborts an operation whose completion never
// arrives.
//
// Ports
//   cpu_clk          sole clock, rising edge
//   rst              asynchronous active-low reset
//   i_req/i_addr     I-cache read request (level, held until i_ack)
//   i_rdata/i_ack    I-cache read data, valid in the one-cycle i_ack pulse
//   d_req/d_we       D-cache request (level) and op type (1 = write)
//   d_addr/d_wdata   D-cache address and write data
//   d_rdata/d_ack    D-cache read data (0 for writes), valid with d_ack
//   cache_ram_valid  one-cycle issue strobe to the bridge
//   cache_ram_write  op type to the bridge (always 0 for I-cache)
//   cache_ram_addr   bridge address, held from issue until completion
//   cache_ram_data   bridge write data, held from issue until completion
//   ram_data         bridge read data, qualified by bram_valid
//   bram_valid       bridge completion pulse
//   arb_err          one-cycle pulse, coincident with the ack of an aborted op
// -----------------------------------------------------------------------------
module cache_ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              cache_ram_valid,
    output logic              cache_ram_write,
    output logic [ADDR_W-1:0] cache_ram_addr,
    output logic [DATA_W-1:0] cache_ram_data,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              bram_valid,
    output logic              arb_err
);

    localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    logic              grant_d;      // current grantee: 1 = D-cache, 0 = I-cache
    logic              last_grant_d; // grantee of the most recent issue
    logic [WDOG_W-1:0] wdog;

    logic              pick_d;
    logic [DATA_W-1:0] resp_data;

    // D-cache wins when it is the only requester, or on a tie when the I-cache
    // was served last. Reset leaves last_grant_d = I, so D takes the first tie.
    assign pick_d = d_req && (!i_req || !last_grant_d);

    // Data returned to the requester: bridge data for a completed read, zero
    // for writes and for a watchdog abort.
    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        resp_data = '0;
        if (bram_valid && !cache_ram_write) begin
            resp_data = ram_data;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            grant_d         <= 1'b0;
            last_grant_d    <= 1'b0;
            wdog            <= '0;
            i_rdata         <= '0;
            i_ack           <= 1'b0;
            d_rdata         <= '0;
            d_ack           <= 1'b0;
            cache_ram_valid <= 1'b0;
            cache_ram_write <= 1'b0;
            cache_ram_addr  <= '0;
            cache_ram_data  <= '0;
            arb_err         <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            cache_ram_valid <= 1'b0;
            i_ack           <= 1'b0;
            d_ack           <= 1'b0;
            arb_err         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        grant_d         <= pick_d;
                        cache_ram_valid <= 1'b1;
                        cache_ram_write <= pick_d && d_we;
                        cache_ram_addr  <= pick_d ? d_addr : i_addr;
                        cache_ram_data  <= pick_d ? d_wdata : '0;
                        state           <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    last_grant_d <= grant_d;
                    wdog         <= '0;
                    state        <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Completion and watchdog expiry share one exit; the
                    // completion pulse wins if both happen on the same edge.
                    if (bram_valid || (wdog == WDOG_LAST)) begin
                        arb_err <= !bram_valid;
                        if (grant_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= resp_data;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= resp_data;
                        end
                        state <= ST_RESP;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end

                ST_RESP: begin
                    // The ack is high during this cycle. Returning to IDLE here
                    // means req is next sampled after the requester has seen ack.
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_ram_arbiter
//
// Requester tasks drive the I and D ports. When a request is issued they push
// the read data they expect, taken from a shadow memory. A bridge model answers
// valid strobes from its own memory. It also checks the issued op against a
// round-robin reference and pushes the expected ack port, error flag and ack
// cycle. A monitor pops both queues whenever an ack appears and compares.
// -----------------------------------------------------------------------------
module tb_cache_ram_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    logic              cpu_clk;
    logic              rst;
    logic              i_req, d_req, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              i_ack, d_ack;
    logic              cache_ram_valid, cache_ram_write;
    logic [ADDR_W-1:0] cache_ram_addr;
    logic [DATA_W-1:0] cache_ram_data;
    logic [DATA_W-1:0] ram_data;
    logic              bram_valid;
    logic              arb_err;

    logic              br_pulse, stray_pulse;
    assign bram_valid = br_pulse | stray_pulse;

    cache_ram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .cpu_clk        (cpu_clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_rdata        (i_rdata),
        .i_ack          (i_ack),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_ack          (d_ack),
        .cache_ram_valid(cache_ram_valid),
        .cache_ram_write(cache_ram_write),
        .cache_ram_addr (cache_ram_addr),
        .cache_ram_data (cache_ram_data),
        .ram_data       (ram_data),
        .bram_valid     (bram_valid),
        .arb_err        (arb_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // ---------------------------------------------------------------- bookkeeping
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int valid_pulses = 0;
    int rst_count   = 0;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    // Request levels as sampled by the DUT on the most recent rising edge.
    logic snap_i = 1'b0, snap_d = 1'b0;
    always @(posedge cpu_clk) begin
        snap_i <= i_req;
        snap_d <= d_req;
    end

    typedef struct {
        logic is_d;
        logic err;
        int   cyc;
    } ack_exp_t;

    ack_exp_t    exp_ack_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];

    // Reference and bridge memories; untouched words read a fixed hash.
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] br_mem[logic [31:0]];

    // Current request records, as seen by the requesters.
    logic [31:0] cur_i_addr = '0, cur_d_addr = '0, cur_d_wdata = '0;
    logic        cur_d_we   = 1'b0;
    logic        ref_last_d = 1'b0;  // round-robin memory: last winner was D

    // Bridge behaviour knobs.
    int   br_lat    = 1;
    logic br_rand   = 1'b0;
    logic br_silent = 1'b0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] br_rd(input logic [31:0] a);
        return br_mem.exists(a) ? br_mem[a] : mem_init(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {59'd0, i_ack, d_ack, cache_ram_valid, cache_ram_write, arb_err}, 64'd0);
        check({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
        check({tag, "_bridge"}, {cache_ram_addr, cache_ram_data}, 64'd0);
    endtask

    // ---------------------------------------------------------------- bridge model
    logic        br_exp_d, br_write;
    logic [31:0] br_addr, br_wdata;
    int          br_lat_cur, br_rst_mark;

    initial begin : bridge
        br_pulse = 1'b0;
        ram_data = '0;
        forever begin
            @(negedge cpu_clk);
            if (cache_ram_valid) begin
                valid_pulses++;
                // Round-robin reference: a lone requester wins; on a tie the
                // requester that was not served last wins.
                check("grant_had_request", {63'd0, snap_i | snap_d}, 64'd1);
                br_exp_d   = (snap_i && snap_d) ? !ref_last_d : snap_d;
                ref_last_d = br_exp_d;
                if (br_exp_d) begin
                    check("bridge_write_d", {63'd0, cache_ram_write}, {63'd0, cur_d_we});
                    check("bridge_addr_d", cache_ram_addr, cur_d_addr);
                    if (cur_d_we) check("bridge_wdata", cache_ram_data, cur_d_wdata);
                end else begin
                    check("bridge_write_i", {63'd0, cache_ram_write}, 64'd0);
                    check("bridge_addr_i", cache_ram_addr, cur_i_addr);
                end
                br_write    = cache_ram_write;
                br_addr     = cache_ram_addr;
                br_wdata    = cache_ram_data;
                br_rst_mark = rst_count;
                br_lat_cur  = br_rand ? int'($urandom_range(1, 4)) : br_lat;
                exp_ack_q.push_back('{is_d: br_exp_d, err: br_silent,
                                      cyc: cyc + (br_silent ? TIMEOUT + 1 : br_lat_cur + 1)});
                @(negedge cpu_clk);
                check("valid_one_cycle", {63'd0, cache_ram_valid}, 64'd0);
                if (!br_silent) begin
                    repeat (br_lat_cur - 1) @(negedge cpu_clk);
                    if (rst_count == br_rst_mark) begin
                        check("addr_held", cache_ram_addr, br_addr);
                    end
                    if (br_write) begin
                        br_mem[br_addr] = br_wdata;
                        ram_data        = $urandom;  // must not reach d_rdata
                    end else begin
                        ram_data = br_rd(br_addr);
                    end
                    br_pulse = 1'b1;
                    @(negedge cpu_clk);
                    br_pulse = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    task automatic ack_seen(input logic is_d);
        ack_exp_t    a;
        logic [31:0] want;
        check("ack_expected", {63'd0, exp_ack_q.size() > 0}, 64'd1);
        if (exp_ack_q.size() > 0) begin
            a = exp_ack_q.pop_front();
            check("ack_port", {63'd0, is_d}, {63'd0, a.is_d});
            check("ack_cycle", 64'(cyc), 64'(a.cyc));
            check("arb_err_with_ack", {63'd0, arb_err}, {63'd0, a.err});
        end
        if (is_d) begin
            check("d_data_expected", {63'd0, exp_d_q.size() > 0}, 64'd1);
            if (exp_d_q.size() > 0) begin
                want = exp_d_q.pop_front();
                check("d_rdata", d_rdata, want);
            end
        end else begin
            check("i_data_expected", {63'd0, exp_i_q.size() > 0}, 64'd1);
            if (exp_i_q.size() > 0) begin
                want = exp_i_q.pop_front();
                check("i_rdata", i_rdata, want);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge cpu_clk);
            if (i_ack) check("no_dual_ack", {63'd0, d_ack}, 64'd0);
            if (arb_err) check("arb_err_only_with_ack", {63'd0, i_ack | d_ack}, 64'd1);
            if (i_ack) ack_seen(1'b0);
            if (d_ack) ack_seen(1'b1);
        end
    end

    // ---------------------------------------------------------------- requesters
    // Both tasks start and end at rising edge + 1, so a zero-gap follow-up
    // request keeps the req level continuously high.
    task automatic do_i(input logic [31:0] addr, input logic tmo, input int gap);
        bit seen;
        repeat (gap) begin @(posedge cpu_clk); #1; end
        cur_i_addr = addr;
        i_addr     = addr;
        i_req      = 1'b1;
        exp_i_q.push_back(tmo ? 32'h0 : ref_rd(addr));
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge cpu_clk);
            seen = i_ack;
        end
        check("i_ack_within_bound", {63'd0, seen}, 64'd1);
        @(posedge cpu_clk); #1;
        i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gap);
        bit seen;
        repeat (gap) begin @(posedge cpu_clk); #1; end
        cur_d_we    = we;
        cur_d_addr  = addr;
        cur_d_wdata = wdata;
        d_we        = we;
        d_addr      = addr;
        d_wdata     = wdata;
        d_req       = 1'b1;
        if (we) begin
            exp_d_q.push_back(32'h0);
            ref_mem[addr] = wdata;
        end else begin
            exp_d_q.push_back(ref_rd(addr));
        end
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge cpu_clk);
            seen = d_ack;
        end
        check("d_ack_within_bound", {63'd0, seen}, 64'd1);
        @(posedge cpu_clk); #1;
        d_req = 1'b0;
    endtask

    // ---------------------------------------------------------------- sequence
    int  vp0;
    bit  seen_valid;

    initial begin : main
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        stray_pulse = 1'b0;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        br_mem[32'h100]  = 32'hDEAD_BEEF;

        repeat (3) @(negedge cpu_clk);
        check_zero("reset");
        rst = 1'b1;
        @(posedge cpu_clk); #1;

        // Single I-cache read, minimum latency.
        do_i(32'h100, 1'b0, 0);

        // D-cache write, then read it back.
        do_d(1'b1, 32'h200, 32'h1234, 0);
        do_d(1'b0, 32'h200, 32'h0, 1);

        // Both requesters held: grants alternate, eight issues total.
        vp0 = valid_pulses;
        fork
            for (int k = 0; k < 4; k++) do_i(32'h1000 + 32'(4 * k), 1'b0, 0);
            for (int k = 0; k < 4; k++) do_d(k[0], 32'h204 + 32'(4 * k), 32'hA000 + 32'(k), 0);
        join
        check("both_held_valid_pulses", 64'(valid_pulses - vp0), 64'd8);

        // Silent bridge: watchdog abort, then normal service resumes.
        br_silent = 1'b1;
        do_i(32'h1080, 1'b1, 0);
        br_silent = 1'b0;
        do_d(1'b0, 32'h200, 32'h0, 0);

        // Reset during WAIT, with the completion arriving after release.
        br_lat     = 6;
        cur_i_addr = 32'h1040;
        i_addr     = 32'h1040;
        i_req      = 1'b1;
        seen_valid = 1'b0;
        for (int n = 0; n < 10 && !seen_valid; n++) begin
            @(negedge cpu_clk);
            seen_valid = cache_ram_valid;
        end
        check("reset_test_issue", {63'd0, seen_valid}, 64'd1);
        @(negedge cpu_clk);
        rst   = 1'b0;
        i_req = 1'b0;
        rst_count++;
        #1;
        check_zero("mid_wait_reset");
        exp_ack_q.delete();
        ref_last_d = 1'b0;
        @(negedge cpu_clk);
        rst = 1'b1;
        repeat (10) @(negedge cpu_clk);
        check("post_reset_quiet", {61'd0, i_ack, d_ack, cache_ram_valid}, 64'd0);
        br_lat = 1;
        @(posedge cpu_clk); #1;
        do_i(32'h1040, 1'b0, 0);

        // Stray completion while idle.
        stray_pulse = 1'b1;
        @(posedge cpu_clk); #1;
        stray_pulse = 1'b0;
        repeat (3) begin
            @(negedge cpu_clk);
            check("stray_no_response", {61'd0, i_ack, d_ack, arb_err}, 64'd0);
        end
        @(posedge cpu_clk); #1;
        do_d(1'b0, 32'h204, 32'h0, 0);

        // Randomised concurrent traffic with random bridge latency.
        br_rand = 1'b1;
        fork
            for (int k = 0; k < 20; k++)
                do_i(32'h1000 + 32'(4 * $urandom_range(0, 15)), 1'b0, int'($urandom_range(0, 3)));
            for (int k = 0; k < 20; k++)
                do_d(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 7)),
                     $urandom, int'($urandom_range(0, 3)));
        join
        br_rand = 1'b0;

        repeat (5) @(negedge cpu_clk);
        check("queues_drained", 64'(exp_ack_q.size() + exp_i_q.size() + exp_d_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : global_bound
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1, "global time bound expired");
    end

endmodule
